bus_drvr_endpoint: RTL
======================

Name: bus_drvr_endpoint

Overview:
- Driver-side endpoint for the parallel bus generator/arbiter: one instance sits on each drvr_N/bus_0 port of the bus.
- Outbound queue: the endpoint presents pndng and D_pop and accepts pop strobes from the arbiter.
- Inbound queue: it accepts push/D_push deliveries from the bus.
- Exposes simple FWFT FIFO ports to the local processing element (matrix-multiplier tile), with destination filtering and error counters.

Parameters:
- bits, 256, packet width. Bits [bits-1:bits-8] are the destination ID; the rest is payload.
- depth, 8, entries per queue (power of two, >=2).
- id, 0, this driver's 8-bit bus ID.
- broadcast, {8{1'b1}}, destination ID accepted by every driver.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- pndng  out  1  outbound queue non-empty (to bus pndng_drvr_N).
- pop  in  1  bus consumes the outbound head this cycle.
- D_pop  out  bits  outbound head packet, valid while pndng=1.
- push  in  1  bus delivers a packet this cycle.
- D_push  in  bits  delivered packet.
- tx_wr  in  1  local write to the outbound queue.
- tx_data  in  bits  local packet; header already holds the destination ID.
- tx_full  out  1  outbound queue full.
- tx_level  out  log2(depth)+1  outbound occupancy.
- rx_valid  out  1  inbound queue non-empty.
- rx_rd  in  1  local consumes the inbound head.
- rx_data  out  bits  inbound head packet, valid while rx_valid=1.
- rx_level  out  log2(depth)+1  inbound occupancy.
- rx_ovf_cnt  out  16  saturating count of pushes dropped because the inbound queue was full.
- rx_mis_cnt  out  16  saturating count of pushes dropped for wrong destination.

Behaviour:
- Reset (synchronous, takes priority over every other input):
  - Both queues empty; pointers and levels 0; pndng=0; rx_valid=0; tx_full=0; counters 0.
  - D_pop and rx_data are don't-care while their queue is empty; the bench must not check them then.
  - Reset mid-operation discards all queued packets.
- Outbound queue:
  - tx_wr is accepted only when tx_full=0. A write to a full queue is ignored, even if pop is asserted in the same cycle. Local logic must honour tx_full.
  - pop is accepted only when pndng=1. pop while empty is ignored, with no pointer change or underflow.
  - FWFT: D_pop shows the head combinationally from storage. A packet written in cycle t raises pndng at t+1.
  - Write and pop in the same cycle (queue non-empty, not full): both take effect and the level is unchanged.
  - Pointers wrap modulo depth. tx_full = (level==depth).
- Inbound queue:
  - On push, let dest = D_push[bits-1:bits-8].
  - If dest is neither id nor broadcast: drop the packet and increment rx_mis_cnt.
  - Otherwise, if the queue is full: drop the packet and increment rx_ovf_cnt. A simultaneous rx_rd does not free space for this push.
  - Otherwise: store the packet. rx_valid rises the next cycle.
  - rx_rd with rx_valid=0 is ignored. Push and rx_rd in the same cycle on a non-empty, non-full queue keep the level constant.
  - Both counters saturate at 16'hFFFF. They clear only on reset.
- Latency: local write to pndng is 1 cycle; push to rx_valid is 1 cycle. There are no combinational paths from pop to pndng, or from push to rx_valid.
- Ordering is strict FIFO in each direction. Broadcast packets are stored like unicast packets.

Decomposition:
- Package bus_pkg:
  - ID_W=8 and BROADCAST_ID=8'hFF.
  - Function dest_of(pkt) returning the top ID_W bits.
  - Shared level-width function clog2(depth)+1.
- Sub-module sync_fifo_fwft (params bits, depth):
  - Ports wr, wr_data, rd, rd_data, empty, full, level.
  - Write-when-full and read-when-empty are ignored.
  - Instantiated twice, for the outbound and inbound queues.
- Top-level logic: address filter and saturating counters.

Test Plan:
- Reset, then write 3 packets with dest 8'h02 and payloads 1,2,3. pndng=1 from the cycle after the first write. Pop each in turn: D_pop yields 1,2,3 in order. pndng=0 after the third pop; tx_level goes 3→0.
- Fill the outbound queue with 8 packets: tx_full=1. A 9th tx_wr with pop held low is ignored. Then tx_wr+pop in the same cycle while full: the level stays 7 after the pop and the write is dropped. Draining yields the original 8 only.
- id=3: push dest 8'h03, then 8'hFF, then 8'h05. Only the first two appear on rx_data, in order. rx_mis_cnt=1.
- Push 10 packets to id=3 with no rx_rd: rx_level=8, rx_ovf_cnt=2. Reading all 8 returns the first 8 packets.
- Push and rx_rd in the same cycle with rx_level=4: the level stays 4 and the head advances. pop while pndng=0 has no effect (tx_level stays 0).
- Assert reset with 5 packets queued in each direction: the next cycle pndng=0, rx_valid=0, levels=0, counters=0.

Source files
------------

// File: rtl/bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : bus_pkg                                                |
// | Description : Shared constants and helpers for the bus driver        |
// |               endpoint: ID width, broadcast ID, destination          |
// |               extraction and FIFO level width.                       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package bus_pkg;

    localparam int ID_W = 8;
    localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;

    // Widest packet the destination helper can take; callers zero-extend.
    localparam int MAX_PKT_W = 1024;

    // Occupancy counter width: must be able to represent 0..depth inclusive.
    function automatic int lvl_w(input int d);
        return $clog2(d) + 1;
    endfunction

    // Destination ID lives in the top ID_W bits of a w-bit packet.
    function automatic logic [ID_W-1:0] dest_of(input logic [MAX_PKT_W-1:0] pkt,
                                                 input int                  w);
        return pkt[w-1 -: ID_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sync_fifo_fwft                                         |
// | Description : Synchronous first-word-fall-through FIFO. Head entry   |
// |               is shown combinationally on rd_data. Writes when full  |
// |               and reads when empty are silently ignored.             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sync_fifo_fwft
    import bus_pkg::*;
#(
    parameter int unsigned bits  = 256,
    parameter int unsigned depth = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr,
    input  logic [bits-1:0]           wr_data,
    input  logic                      rd,
    output logic [bits-1:0]           rd_data,
    output logic                      empty,
    output logic                      full,
    output logic [lvl_w(depth)-1:0]   level
);

    localparam int PW = $clog2(depth);
    localparam int LW = lvl_w(depth);
    localparam logic [LW-1:0] C_DEPTH = LW'(depth);

    logic [bits-1:0] r_mem_q [depth];
    logic [PW-1:0]   r_wr_ptr_q;
    logic [PW-1:0]   r_rd_ptr_q;
    logic [LW-1:0]   r_level_q;
    logic [LW-1:0]   w_level_d;
    logic            w_do_wr;
    logic            w_do_rd;

    // Full/empty are judged on the current level only, so a same-cycle read
    // never makes room for a write that arrives while full.
    assign full    = (r_level_q == C_DEPTH);
    assign empty   = (r_level_q == '0);
    assign w_do_wr = wr && !full;
    assign w_do_rd = rd && !empty;
    assign rd_data = r_mem_q[r_rd_ptr_q];
    assign level   = r_level_q;

    // Next occupancy from the accepted write/read pair.
    always_comb begin
        w_level_d = r_level_q;
        if (w_do_wr && !w_do_rd) begin
            w_level_d = r_level_q + LW'(1);
        end else if (!w_do_wr && w_do_rd) begin
            w_level_d = r_level_q - LW'(1);
        end
    end

    // Pointer and level registers; pointers wrap naturally at power-of-two depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_level_q  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr_q <= r_wr_ptr_q + PW'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr_q <= r_rd_ptr_q + PW'(1);
            end
            r_level_q <= w_level_d;
        end
    end

    // Storage array; contents need no reset since the level gates visibility.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem_q[r_wr_ptr_q] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_drvr_endpoint.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : bus_drvr_endpoint                                      |
// | Description : Driver-side bus endpoint. Outbound FWFT queue feeds    |
// |               the arbiter (pndng/pop/D_pop); inbound FWFT queue      |
// |               takes filtered deliveries (push/D_push). Drops are     |
// |               tallied in saturating mis-destination/overflow counts. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module bus_drvr_endpoint
    import bus_pkg::*;
#(
    parameter int unsigned     bits      = 256,
    parameter int unsigned     depth     = 8,
    parameter logic [ID_W-1:0] id        = 8'd0,
    parameter logic [ID_W-1:0] broadcast = BROADCAST_ID
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     pndng,
    input  logic                     pop,
    output logic [bits-1:0]          D_pop,
    input  logic                     push,
    input  logic [bits-1:0]          D_push,
    input  logic                     tx_wr,
    input  logic [bits-1:0]          tx_data,
    output logic                     tx_full,
    output logic [lvl_w(depth)-1:0]  tx_level,
    output logic                     rx_valid,
    input  logic                     rx_rd,
    output logic [bits-1:0]          rx_data,
    output logic [lvl_w(depth)-1:0]  rx_level,
    output logic [15:0]              rx_ovf_cnt,
    output logic [15:0]              rx_mis_cnt
);

    localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

    logic            w_tx_empty;
    logic            w_rx_empty;
    logic            w_rx_full;
    logic [ID_W-1:0] w_dest;
    logic            w_match;
    logic            w_mis_inc;
    logic            w_ovf_inc;
    logic [15:0]     r_ovf_cnt_q;
    logic [15:0]     r_mis_cnt_q;
    logic [15:0]     w_ovf_cnt_d;
    logic [15:0]     w_mis_cnt_d;

    // Outbound queue: local writes in, arbiter pops out.
    sync_fifo_fwft #(
        .bits  (bits),
        .depth (depth)
    ) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr      (tx_wr),
        .wr_data (tx_data),
        .rd      (pop),
        .rd_data (D_pop),
        .empty   (w_tx_empty),
        .full    (tx_full),
        .level   (tx_level)
    );

    assign pndng = !w_tx_empty;

    // Address filter: accept our own ID or the broadcast ID.
    assign w_dest    = dest_of(MAX_PKT_W'(D_push), bits);
    assign w_match   = (w_dest == id) || (w_dest == broadcast);
    assign w_mis_inc = push && !w_match;
    assign w_ovf_inc = push && w_match && w_rx_full;

    // Inbound queue: filtered bus deliveries in, local reads out.
    sync_fifo_fwft #(
        .bits  (bits),
        .depth (depth)
    ) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr      (push && w_match),
        .wr_data (D_push),
        .rd      (rx_rd),
        .rd_data (rx_data),
        .empty   (w_rx_empty),
        .full    (w_rx_full),
        .level   (rx_level)
    );

    assign rx_valid = !w_rx_empty;

    // Saturating drop counters: stick at all-ones until reset.
    always_comb begin
        w_ovf_cnt_d = r_ovf_cnt_q;
        w_mis_cnt_d = r_mis_cnt_q;
        if (w_ovf_inc && (r_ovf_cnt_q != C_CNT_MAX)) begin
            w_ovf_cnt_d = r_ovf_cnt_q + 16'd1;
        end
        if (w_mis_inc && (r_mis_cnt_q != C_CNT_MAX)) begin
            w_mis_cnt_d = r_mis_cnt_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf_cnt_q <= '0;
            r_mis_cnt_q <= '0;
        end else begin
            r_ovf_cnt_q <= w_ovf_cnt_d;
            r_mis_cnt_q <= w_mis_cnt_d;
        end
    end

    assign rx_ovf_cnt = r_ovf_cnt_q;
    assign rx_mis_cnt = r_mis_cnt_q;

endmodule
`default_nettype wire
